// File: rtl/cprs_pkg.sv
// Shared types and constants for the bit-count compressor datapath.
package cprs_pkg;

   typedef enum logic [1:0] {
      CPRS_IDLE = 2'd0,
      CPRS_RUN  = 2'd1,
      CPRS_DONE = 2'd2
   } cprs_seq_state_t;

   localparam int CPRS_ERR_WEIGHT = 4;
   localparam int CPRS_NIB_W      = 4;

endpackage

// File: rtl/cprs_4_2.sv
// 4:2 compressor cell: 2-bit ones-count of a nibble; err flags the all-ones
// nibble whose count of 4 does not fit in the 2-bit output.
module cprs_4_2
   import cprs_pkg::*;
(
   input  logic [CPRS_NIB_W-1:0] din,
   output logic [1:0]            out,
   output logic                  err
);

   logic [2:0] sum;

   assign sum = {2'b00, din[0]} + {2'b00, din[1]} + {2'b00, din[2]} + {2'b00, din[3]};
   assign out = sum[1:0];
   assign err = &din;

endmodule

// File: rtl/cprs_seq_ctrl.sv
// Time-shares one cprs_4_2 cell across a wide word to produce its ones-count.
// Optional macro CPRS_SEQ_ERRCNT_EN builds the err-event counter.
module cprs_seq_ctrl
   import cprs_pkg::*;
#(
   parameter int N_NIB = 8,
   parameter int CNT_W = $clog2(4*N_NIB+1),
   parameter int ERR_W = $clog2(N_NIB+1)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4*N_NIB-1:0]      in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CNT_W-1:0]        out_count,
   output logic [ERR_W-1:0]        out_err_cnt,
   output logic                    busy
);

   localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;

   cprs_seq_state_t          state;
   logic [4*N_NIB-1:0]       sreg;
   logic [IDX_W-1:0]         idx;
   logic [CNT_W-1:0]         acc_cnt;
   logic [1:0]               nib_out;
   logic                     nib_err;
   logic [CNT_W-1:0]         contrib;

   cprs_4_2 u_cprs (
      .din (sreg[CPRS_NIB_W-1:0]),
      .out (nib_out),
      .err (nib_err)
   );

   // An all-ones nibble overflows the cell's 2-bit count, so err stands in for 4.
   assign contrib = nib_err ? CNT_W'(CPRS_ERR_WEIGHT) : CNT_W'(nib_out);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= CPRS_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sreg      <= '0;
         idx       <= '0;
         acc_cnt   <= '0;
      end else begin
         case (state)
            CPRS_IDLE: begin
               if (in_valid) begin
                  sreg     <= in_data;
                  acc_cnt  <= '0;
                  idx      <= '0;
                  state    <= CPRS_RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            CPRS_RUN: begin
               acc_cnt <= acc_cnt + contrib;
               sreg    <= sreg >> CPRS_NIB_W;
               idx     <= idx + IDX_W'(1);
               if (idx == IDX_W'(N_NIB-1)) begin
                  state     <= CPRS_DONE;
                  out_valid <= 1'b1;
               end
            end
            CPRS_DONE: begin
               if (out_ready) begin
                  state     <= CPRS_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= CPRS_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_count = acc_cnt;

`ifdef CPRS_SEQ_ERRCNT_EN
   logic [ERR_W-1:0] acc_err;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         acc_err <= '0;
      end else if (state == CPRS_IDLE && in_valid) begin
         acc_err <= '0;
      end else if (state == CPRS_RUN && nib_err) begin
         acc_err <= acc_err + ERR_W'(1);
      end
   end

   assign out_err_cnt = acc_err;
`else
   assign out_err_cnt = '0;
`endif

endmodule

// File: tb/tb_cprs_seq_ctrl.sv
// Directed bench for cprs_seq_ctrl with N_NIB=8 and N_NIB=1 instances.
module tb_cprs_seq_ctrl;

   logic        clk = 1'b0;
   logic        rstn;

   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [31:0] in_data;
   logic [5:0]  out_count;
   logic [3:0]  out_err_cnt;

   logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
   logic [3:0]  in_data1;
   logic [2:0]  out_count1;
   logic [0:0]  out_err_cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cprs_seq_ctrl #(.N_NIB(8)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_count(out_count), .out_err_cnt(out_err_cnt), .busy(busy)
   );

   cprs_seq_ctrl #(.N_NIB(1)) dut1 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_count(out_count1), .out_err_cnt(out_err_cnt1), .busy(busy1)
   );

   typedef struct {
      logic [31:0] data;
      int          cnt;
      int          err;
   } vec_t;

   function automatic int exp_err(input int e);
`ifdef CPRS_SEQ_ERRCNT_EN
      return e;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_result(input string nm, input int lat);
      int n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, " latency"}, n, lat);
   endtask

   task automatic do_word(input logic [31:0] d, input int ec, input int ee, input string nm);
      @(negedge clk);
      chk({nm, " in_ready idle"}, int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({nm, " in_ready run"}, int'(in_ready), 0);
      wait_result(nm, 8);
      chk({nm, " count"}, int'(out_count), ec);
      chk({nm, " err_cnt"}, int'(out_err_cnt), exp_err(ee));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, " out_valid after hs"}, int'(out_valid), 0);
      chk({nm, " in_ready after hs"}, int'(in_ready), 1);
   endtask

   task automatic do_word1(input logic [3:0] d, input int ec, input int ee, input string nm);
      int n = 0;
      @(negedge clk);
      in_valid1 = 1'b1;
      in_data1  = d;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      while (!out_valid1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, " latency"}, n, 1);
      chk({nm, " count"}, int'(out_count1), ec);
      chk({nm, " err_cnt"}, int'(out_err_cnt1), exp_err(ee));
      @(negedge clk);
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      chk({nm, " out_valid after hs"}, int'(out_valid1), 0);
   endtask

   initial begin
      vec_t vecs[7];
      logic [5:0] held_cnt;
      logic [3:0] held_err;

      vecs[0] = '{32'h0000_0000, 0, 0};
      vecs[1] = '{32'hFFFF_FFFF, 32, 8};
      vecs[2] = '{32'h0000_000F, 4, 1};
      vecs[3] = '{32'h1234_5678, 13, 0};
      vecs[4] = '{32'hA5A5_A5A5, 16, 0};
      vecs[5] = '{32'hF0F0_F0F0, 16, 4};
      vecs[6] = '{32'h8000_0001, 2, 0};

      rstn = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", int'(in_ready), 1);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset out_count", int'(out_count), 0);
      chk("reset out_err_cnt", int'(out_err_cnt), 0);
      chk("reset busy", int'(busy), 0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 7; i++)
         do_word(vecs[i].data, vecs[i].cnt, vecs[i].err, $sformatf("vec%0d", i));

      // Stalled result followed by a back-to-back second word
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h0F0F_0F0F;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_result("stall A", 8);
      chk("stall A count", int'(out_count), 16);
      chk("stall A err_cnt", int'(out_err_cnt), exp_err(4));
      held_cnt = out_count;
      held_err = out_err_cnt;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk($sformatf("stall out_valid c%0d", c), int'(out_valid), 1);
         chk($sformatf("stall count c%0d", c), int'(out_count), int'(held_cnt));
         chk($sformatf("stall err c%0d", c), int'(out_err_cnt), int'(held_err));
         chk($sformatf("stall in_ready c%0d", c), int'(in_ready), 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h0000_0007;
      @(posedge clk); #1;
      chk("b2b in_ready after hs", int'(in_ready), 1);
      chk("b2b out_valid after hs", int'(out_valid), 0);
      @(negedge clk);
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b accepted", int'(in_ready), 0);
      chk("b2b busy", int'(busy), 1);
      wait_result("b2b B", 8);
      chk("b2b B count", int'(out_count), 3);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset mid-RUN at idx=3
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      @(posedge clk); #1;
      chk("midrst in_ready", int'(in_ready), 1);
      chk("midrst out_valid", int'(out_valid), 0);
      chk("midrst out_count", int'(out_count), 0);
      chk("midrst out_err_cnt", int'(out_err_cnt), 0);
      chk("midrst busy", int'(busy), 0);
      @(negedge clk);
      rstn = 1'b1;
      do_word(32'h0000_00FF, 8, 2, "after rst");

      do_word1(4'hF, 4, 1, "n1 F");
      do_word1(4'h7, 3, 0, "n1 7");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cprs_seq_ctrl.md
# cprs_seq_ctrl

Sequencing controller that time-shares a single `cprs_4_2` compressor cell across a wide input word to produce a ones-count. It accepts one word per valid/ready handshake and feeds it nibble by nibble through the compressor. It accumulates each nibble's contribution and returns the total count plus an error-event count on a valid/ready output. It sits between the operand buffer and the MAC accumulator in the bit-count datapath.

## Interface
- `N_NIB`, default 8: nibbles per input word; minimum 1.
- `CNT_W`, default `$clog2(4*N_NIB+1)`: width of the ones-count.
- `ERR_W`, default `$clog2(N_NIB+1)`: width of the err-event count.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rstn`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: controller can accept a word.
- `in_data`  in  4*N_NIB: operand word; nibble 0 is `[3:0]`.
- `out_valid`  out  1: result is valid.
- `out_ready`  in  1: consumer takes the result.
- `out_count`  out  CNT_W: total ones-count of the word.
- `out_err_cnt`  out  ERR_W: number of nibbles for which the compressor asserted `err`.
- `busy`  out  1: high in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `in_ready`=1.
  - `in_valid && in_ready` at an edge: capture `in_data` into a shift register, clear the accumulators, set nibble index `idx`=0, go to RUN.
- **RUN**
  - The compressor input is the low nibble of the shift register.
  - Per-nibble contribution: `err` ? 4 : zero-extended `out`. A nibble of 1111 therefore contributes 4.
  - Each edge: add the contribution to `acc_cnt`, increment `acc_err` if `err`, shift the register right by 4, increment `idx`.
  - On the edge where `idx`==N_NIB-1, go to DONE.
- **DONE**
  - `out_valid`=1.
  - `out_count`/`out_err_cnt` show the accumulators and stay stable until `out_ready`.
  - `out_valid && out_ready` at an edge: go to IDLE.
- **Arithmetic**
  - Accumulators are unsigned and cannot overflow: CNT_W covers 4*N_NIB and ERR_W covers N_NIB.
- **Reset**
  - Reset at any point, including mid-RUN, aborts the operation and returns to IDLE.
  - Reset values: `in_ready`=1, `out_valid`=0, `out_count`=0, `out_err_cnt`=0, `busy`=0.
- **Input during RUN/DONE**
  - `in_ready`=0; `in_data` is ignored and the producer must hold it.

## Timing
- Accept at edge k.
- `out_valid` rises after edge k+N_NIB, i.e. latency is N_NIB cycles from accept to result.
- The earliest next accept is the edge after the result handshake: throughput is one word per N_NIB+2 cycles with `out_ready` tied high.
- No combinational path from `out_ready` to `in_ready`; `in_ready` is a decode of registered state.
- `out_valid` and the result fields are registered, with no glitching while stalled.
- N_NIB=1: RUN lasts exactly one cycle.

## Configuration
- `CPRS_SEQ_ERRCNT_EN`
  - Defined: `acc_err` is built and `out_err_cnt` reports the err-event count.
  - Undefined: the `acc_err` register is removed and `out_err_cnt` is tied to 0. `out_count` behaviour is unchanged, since err still selects the contribution of 4.

## Structure
- Shared package `cprs_pkg`:
  - FSM state enum `cprs_seq_state_t`.
  - Localparam `CPRS_ERR_WEIGHT`=4.
  - Nibble width constant `CPRS_NIB_W`=4.
- Exactly one sub-module: an instance of the existing `cprs_4_2` cell.
- FSM, shift register and accumulators live in `cprs_seq_ctrl` itself.

## Test plan
All scenarios use N_NIB=8 unless stated.
- Word 0x00000000 -> `out_valid` 8 cycles after accept, `out_count`=0, `out_err_cnt`=0.
- Word 0xFFFFFFFF -> `out_count`=32, `out_err_cnt`=8 (0 with macro undefined).
- Word 0x0000000F -> `out_count`=4, `out_err_cnt`=1; word 0x12345678 -> `out_count`=13, `out_err_cnt`=0.
- Back-to-back words, `out_ready` held low for 5 cycles in DONE:
  - Result held stable and `in_ready`=0 throughout.
  - Second word accepted the edge after the handshake.
- `rstn` low for 1 cycle at `idx`=3 -> next cycle `in_ready`=1, `out_valid`=0, counts 0; a following word 0x000000FF gives `out_count`=8.
- N_NIB=1, words 0xF then 0x7 -> counts 4 then 3, each after 1 cycle.
